par_unary_gen_lanes: RTL and testbench

- Binary-to-parallel-unary stream generator, the transmit side of the parallel lane accumulators.
- Accepts a binary value and emits it over LANES parallel 1-bit lanes as a thermometer-coded burst.
- The total number of ones across the burst equals the value.
- Feeds par_acc_*lanes counters and DSC lane datapaths in the arch sweep.

---
 rtl/par_unary_gen_lanes.sv | 84 ++++++++
 tb/tb_par_unary_gen_lanes.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/par_unary_gen_lanes.sv
// Binary-to-parallel-unary burst generator: encodes a binary count as thermometer-coded
// beats over LANES 1-bit lanes, with valid/ready handshakes on both sides.
module par_unary_gen_lanes #(
  parameter int unsigned LANES = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] data_out,
  output logic             out_last,
  output logic             done
);

  localparam logic [WIDTH-1:0] LanesW = WIDTH'(LANES);

  typedef enum logic {StIdle, StEmit} state_e;

  state_e           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_next;

  // Lane i is lit when more than i units remain, i.e. (1 << min(r, LANES)) - 1.
  function automatic logic [LANES-1:0] therm(input logic [WIDTH-1:0] r);
    logic [LANES-1:0] t;
    t = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      t[i] = (r > WIDTH'(i));
    end
    return t;
  endfunction

  // Only consumed on a non-last beat, where rem > LANES, so it never wraps.
  assign rem_next = rem - LanesW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      rem       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            rem       <= value;
            state     <= StEmit;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            data_out  <= therm(value);
            out_last  <= (value <= LanesW);
          end
        end
        StEmit: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= StIdle;
              rem       <= '0;
              out_valid <= 1'b0;
              data_out  <= '0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              in_ready  <= 1'b1;
            end else begin
              rem      <= rem_next;
              data_out <= therm(rem_next);
              out_last <= (rem_next <= LanesW);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_par_unary_gen_lanes.sv
// Directed bench for par_unary_gen_lanes with LANES=8, WIDTH=8.
module tb_par_unary_gen_lanes;

  localparam int LANES = 8;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] value;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] data_out;
  logic             out_last;
  logic             done;

  int tests;
  int fails;

  logic [LANES-1:0] beats[$];
  logic             lasts[$];

  par_unary_gen_lanes #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_last (out_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present v for one cycle and check first beat appears one cycle after acceptance.
  task automatic send(input logic [WIDTH-1:0] v);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    value    = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_beat_latency: out_valid %b want 1", out_valid);
    end
  endtask

  // Accept beats until out_last, stalling stall_cycles on beat index stall_beat.
  // Returns at the cycle where done must be high; checks done/in_ready there.
  task automatic collect(input int stall_beat, input int stall_cycles,
                         output int nbeats, output int ones);
    int               stalls;
    int               cyc;
    bit               fin;
    logic [LANES-1:0] held;
    logic             held_last;
    stalls = 0;
    cyc    = 0;
    fin    = 0;
    nbeats = 0;
    ones   = 0;
    held   = '0;
    held_last = 1'b0;
    beats.delete();
    lasts.delete();
    while (!fin && cyc < 100) begin
      if (out_valid === 1'b1) begin
        if (nbeats == stall_beat && stalls < stall_cycles) begin
          if (stalls == 0) begin
            held      = data_out;
            held_last = out_last;
          end else begin
            tests++;
            if (data_out !== held || out_last !== held_last) begin
              fails++;
              $display("FAIL stall_stable: data %h last %b want %h %b",
                       data_out, out_last, held, held_last);
            end
          end
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = 1'b1;
          beats.push_back(data_out);
          lasts.push_back(out_last);
          ones += $countones(data_out);
          nbeats++;
          if (out_last === 1'b1) fin = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL collect_timeout: beats %0d, no out_last within bound", nbeats);
    end
    tests++;
    if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done %b in_ready %b out_valid %b want 1 1 0",
               done, in_ready, out_valid);
    end
  endtask

  task automatic check_done_drops();
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_one_cycle: done %b want 0", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 ||
        out_last !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: rdy %b vld %b data %h last %b done %b want 1 0 00 0 0",
               in_ready, out_valid, data_out, out_last, done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int n, ones;
    send(8'd19);
    collect(-1, 0, n, ones);
    tests++;
    if (n != 3 || beats[0] !== 8'hFF || beats[1] !== 8'hFF || beats[2] !== 8'h07) begin
      fails++;
      $display("FAIL basic_19_beats: n %0d got %h %h %h want 3 FF FF 07",
               n, beats[0], beats[1], beats[2]);
    end
    tests++;
    if (lasts[0] !== 1'b0 || lasts[1] !== 1'b0 || lasts[2] !== 1'b1) begin
      fails++;
      $display("FAIL basic_19_last: got %b%b%b want 001", lasts[0], lasts[1], lasts[2]);
    end
    check_done_drops();
  endtask

  task automatic test_zero();
    int n, ones;
    send(8'd0);
    collect(-1, 0, n, ones);
    tests++;
    if (n != 1 || beats[0] !== 8'h00 || lasts[0] !== 1'b1) begin
      fails++;
      $display("FAIL zero_value: n %0d data %h last %b want 1 00 1", n, beats[0], lasts[0]);
    end
    check_done_drops();
  endtask

  task automatic test_max();
    int n, ones;
    bit body_ok;
    send(8'd255);
    collect(-1, 0, n, ones);
    body_ok = 1;
    for (int i = 0; i < 31 && i < n; i++) begin
      if (beats[i] !== 8'hFF || lasts[i] !== 1'b0) body_ok = 0;
    end
    tests++;
    if (n != 32 || ones != 255) begin
      fails++;
      $display("FAIL max_count: beats %0d ones %0d want 32 255", n, ones);
    end
    tests++;
    if (!body_ok || n != 32 || beats[31] !== 8'h7F || lasts[31] !== 1'b1) begin
      fails++;
      $display("FAIL max_shape: body_ok %0d last beat %h want 1 7F", body_ok,
               (n > 0) ? beats[n-1] : 8'hxx);
    end
    check_done_drops();
  endtask

  task automatic test_backpressure();
    int n, ones;
    send(8'd20);
    collect(1, 3, n, ones);
    tests++;
    if (n != 3 || beats[0] !== 8'hFF || beats[1] !== 8'hFF || beats[2] !== 8'h0F ||
        lasts[2] !== 1'b1) begin
      fails++;
      $display("FAIL stall_sequence: n %0d got %h %h %h want 3 FF FF 0F",
               n, beats[0], beats[1], beats[2]);
    end
    check_done_drops();
  endtask

  // in_valid held high with another value while busy must not be captured.
  task automatic test_ignore_busy();
    int n, ones;
    send(8'd9);
    value    = 8'd3;
    in_valid = 1'b1;
    collect(-1, 0, n, ones);
    in_valid = 1'b0;
    tests++;
    if (n != 2 || beats[0] !== 8'hFF || beats[1] !== 8'h01) begin
      fails++;
      $display("FAIL ignore_busy: n %0d got %h %h want 2 FF 01", n, beats[0], beats[1]);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ignore_busy_idle: vld %b rdy %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n, ones;
    send(8'd40);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || data_out !== 8'h00 || done !== 1'b0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_async: vld %b data %h done %b last %b rdy %b want 0 00 0 0 1",
               out_valid, data_out, done, out_last, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_quiet: done %b vld %b want 0 0", done, out_valid);
    end
    send(8'd5);
    collect(-1, 0, n, ones);
    tests++;
    if (n != 1 || beats[0] !== 8'h1F || lasts[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_after: n %0d data %h want 1 1F", n, beats[0]);
    end
  endtask

  // Sink is an 8-bit accumulator with sticky overflow fed by beat popcounts.
  task automatic test_loopback();
    logic [WIDTH-1:0] vals[8];
    logic [7:0]       acc;
    logic             ovf;
    logic [8:0]       sum9;
    int               ref_sum;
    int               n, ones;
    vals = '{8'd37, 8'd200, 8'd0, 8'd8, 8'd255, 8'd13, 8'd64, 8'd1};
    acc     = '0;
    ovf     = 1'b0;
    ref_sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(vals[i]);
      collect(-1, 0, n, ones);
      for (int b = 0; b < n; b++) begin
        sum9 = {1'b0, acc} + 9'($countones(beats[b]));
        acc  = sum9[7:0];
        ovf  = ovf | sum9[8];
      end
      ref_sum += int'(vals[i]);
      tests++;
      if (acc !== 8'(ref_sum % 256) || ovf !== (ref_sum > 255)) begin
        fails++;
        $display("FAIL loopback_%0d: acc %0d ovf %b want %0d %b", i, acc, ovf,
                 ref_sum % 256, (ref_sum > 255));
      end
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    in_valid  = 1'b0;
    value     = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
